// File: rtl/param_bin_search.sv
// Fixed-latency binary search over a sorted, flattened array.
// Performs lower-bound search; exact-match mode just tightens the found flag.
module param_bin_search #(
    parameter int W   = 8,
    parameter int N   = 8,
    parameter int SGN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*W-1:0]          data,
    input  logic                    en,
    input  logic [W-1:0]            key,
    input  logic                    mode,
    output logic [$clog2(N):0]      idx,
    output logic                    found,
    output logic                    rdy,
    output logic                    valid
);
    localparam int IDXW = $clog2(N);
    localparam int CW   = $clog2(IDXW + 2);
    localparam logic [CW-1:0]   STEPS = CW'(IDXW + 1);
    localparam logic [IDXW:0]   N_POS = (IDXW + 1)'(N);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t               state_reg, state_next;
    logic [N*W-1:0]       data_reg;
    logic [W-1:0]         key_reg;
    logic                 mode_reg;
    logic [IDXW:0]        lo_reg, lo_next;
    logic [IDXW:0]        hi_reg, hi_next;
    logic [IDXW:0]        idx_reg, idx_next;
    logic                 found_reg, found_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 load;

    logic [W-1:0]         elem [N];
    logic [IDXW+1:0]      sum;
    logic [IDXW:0]        mid;
    logic [W-1:0]         mid_elem;
    logic [W-1:0]         lo_elem;
    logic                 mid_lt;
    logic                 lo_in;
    logic                 unused_bits;

    // Element 0 is the most significant slice of the flattened bus.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign elem[gi] = data_reg[(N-1-gi)*W +: W];
        end
    endgenerate

    // One extra bit keeps lo+hi from wrapping when hi == N.
    assign sum         = {1'b0, lo_reg} + {1'b0, hi_reg};
    assign mid         = sum[IDXW+1:1];
    assign unused_bits = sum[0];
    assign mid_elem    = elem[mid[IDXW-1:0]];
    assign lo_elem     = elem[lo_reg[IDXW-1:0]];
    assign lo_in       = (lo_reg < N_POS);

    generate
        if (SGN != 0) begin : g_signed
            assign mid_lt = $signed(mid_elem) < $signed(key_reg);
        end else begin : g_unsigned
            assign mid_lt = mid_elem < key_reg;
        end
    endgenerate

    assign rdy   = (state_reg == IDLE) || (state_reg == DONE);
    assign valid = (state_reg == DONE);
    assign idx   = idx_reg;
    assign found = found_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lo_reg    <= '0;
            hi_reg    <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            found_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            found_reg <= found_next;
        end
    end

    // Operands only change on an accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            key_reg  <= '0;
            mode_reg <= 1'b0;
        end else if (load) begin
            data_reg <= data;
            key_reg  <= key;
            mode_reg <= mode;
        end
    end

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        found_next = found_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (en) begin
                    load       = 1'b1;
                    lo_next    = '0;
                    hi_next    = N_POS;
                    cnt_next   = '0;
                    state_next = SEARCH;
                end else begin
                    state_next = IDLE;
                end
            end
            SEARCH: begin
                if (cnt_reg == STEPS) begin
                    state_next = DONE;
                    idx_next   = lo_reg;
                    found_next = lo_in && (mode_reg || (lo_elem == key_reg));
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                    // Narrowing stops once lo meets hi; remaining steps idle.
                    if (lo_reg < hi_reg) begin
                        if (mid_lt) begin
                            lo_next = mid + (IDXW + 1)'(1);
                        end else begin
                            hi_next = mid;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/param_bin_search.md
PARAM_BIN_SEARCH -- requirements
Module: param_bin_search

Interface
REQ-001 W, 8, element width in bits (SHALL be >= 2).
REQ-002 N, 8, element count (SHALL be a power of two, >= 2); IDXW = log2(N).
REQ-003 SGN, 0, compare mode: 0 = unsigned, 1 = two's-complement signed.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 data  in  N*W  sorted array; element i = data[(N-1-i)*W +: W] (first-concatenated element is index 0), ascending with i.
REQ-007 en  in  1  start request, sampled on rising clk.
REQ-008 key  in  W  search key.
REQ-009 mode  in  1  0 = exact match, 1 = lower bound (first element >= key).
REQ-010 idx  out  IDXW+1  result position p, range 0..N.
REQ-011 found  out  1  match flag, defined per REQ-021.
REQ-012 rdy  out  1  high when a new en is accepted.
REQ-013 valid  out  1  one-cycle pulse; idx and found are valid while it is high.

Function
REQ-014 FSM states: IDLE, SEARCH, DONE.
REQ-015 Accept = en && rdy at edge E0. At acceptance the block SHALL latch data, key and mode; set lo=0, hi=N; clear the step counter; enter SEARCH; deassert rdy.
REQ-016 en while rdy=0 SHALL be ignored, and SHALL NOT disturb the latched operands.
REQ-017 SEARCH step, one per edge:
 - mid = (lo+hi)>>1, computed at IDXW+2 bits with no overflow.
 - if lo<hi and a[mid] < key: lo = mid+1.
 - else if lo<hi: hi = mid.
 - if lo==hi: no change.
REQ-018 SEARCH SHALL run exactly IDXW+1 steps (edges E1..E(IDXW+1)) regardless of data, giving fixed latency.
REQ-019 Compare SHALL be unsigned when SGN=0 and signed when SGN=1.
REQ-020 At edge E(IDXW+2) (the DONE transition): idx = lo, valid = 1, rdy = 1; state returns to IDLE on the following edge.
REQ-021 found:
 - mode 0: found = (p<N) && (a[p]==key).
 - mode 1: found = (p<N).
REQ-022 idx and found SHALL hold until the next result is registered; valid SHALL be high for exactly one cycle per accepted request.
REQ-023 en asserted in the valid cycle SHALL be accepted (back-to-back operation, throughput one search per IDXW+2 cycles).
REQ-024 Key below all elements SHALL give p=0. Key above all elements SHALL give p=N and found=0 in both modes.
REQ-025 With duplicate elements, p SHALL be the lowest index equal to key.
REQ-026 Unsorted data: result unspecified but SHALL still complete in IDXW+2 cycles (no hang).

Reset
REQ-027 rst high SHALL force immediately, without a clock: state IDLE, rdy=1, valid=0, idx=0, found=0, lo=0, hi=0, counter 0.
REQ-028 rst during SEARCH or DONE SHALL abort the search with no valid pulse. The first en after rst deasserts SHALL be accepted normally.

Verification
REQ-029 Defaults, data={20,30,40,50,60,70,80,90}, mode 0, key 30, en one cycle -> rdy low from E1; valid high exactly 5 cycles after accept (E0+5); idx=1, found=1.
REQ-030 Same data, mode 0, key 35 -> idx=2, found=0. Then mode 1, key 35 -> idx=2, found=1.
REQ-031 Same data, mode 1: key 10 -> idx=0, found=1; key 95 -> idx=8, found=0; key 90 -> idx=7, found=1.
REQ-032 Key 70 accepted, en re-pulsed while busy with key 20 -> ignored, result idx=5. en held in valid cycle with key 80 -> accepted, next valid 5 cycles later with idx=6.
REQ-033 rst pulsed 2 cycles after accept -> rdy=1, valid=0, idx=0 immediately; no valid pulse follows; the next request completes correctly.
REQ-034 N=16, W=16, SGN=1, data = -800..700 step 100, mode 0, key -300 -> valid at E0+6, idx=5, found=1. Same with SGN=0 -> result differs from the signed case, with no hang.
